fread_loader: RTL and testbench
===============================

FREAD_LOADER -- requirements
Module: fread_loader

Interface
REQ-001 Parameter FILE_ID, 32'hDABBAD00, ESP32 file ID placed on req_file_id.
REQ-002 Parameter DEPTH, 64, buffer bytes; power of two, 2..4096; AW = log2(DEPTH).
REQ-003 Parameter CHUNK, 64, bytes per fread request; 1..1024; SHALL divide DEPTH.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle load request pulse.
REQ-007 base_offset  in  32  file byte offset of first byte; sampled on accepted start.
REQ-008 busy  out  1  high in any state other than IDLE and DONE.
REQ-009 done  out  1  high in DONE.
REQ-010 req_file_id  out  32  constant FILE_ID.
REQ-011 req_offset  out  32  current chunk file offset.
REQ-012 req_len  out  10  constant CHUNK-1.
REQ-013 req_valid  out  1 / req_ready  in  1  fread request handshake.
REQ-014 resp_data  in  8 / resp_valid  in  1  fread stream reply.
REQ-015 rd_addr  in  AW / rd_data  out  8  random readback port.
REQ-016 out_data  out  8 / out_valid  out  1 / out_ack  in  1  dump stream (UART-style valid/ack).

Function
REQ-017 FSM states: IDLE, REQ, RECV, DUMP, DONE.
REQ-018 IDLE or DONE + start: wr_ptr<=0, chunk_cnt<=0, req_offset<=base_offset, go REQ; start ignored in every other state.
REQ-019 REQ: req_valid=1, held stable until the cycle req_ready=1; then req_valid drops next cycle and FSM enters RECV.
REQ-020 RECV: each resp_valid cycle writes resp_data to mem[wr_ptr], increments wr_ptr (mod DEPTH) and chunk_cnt.
REQ-021 RECV, write of CHUNK-th byte: if wr_ptr wraps to 0 go DUMP (or DONE per REQ-030); else req_offset += CHUNK (mod 2^32), chunk_cnt<=0, go REQ.
REQ-022 resp_valid outside RECV SHALL be ignored; no write, no pointer change.
REQ-023 DUMP: out_data=mem[rd_ptr], out_valid=1; on out_ack rd_ptr++ and out_valid drops for exactly one cycle (re-fetch); after DEPTH acks go DONE.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ack=0.
REQ-025 rd_data = mem[rd_addr] registered, one-cycle latency, valid in all states; same-cycle write to same address returns old data.
REQ-026 Total requests per load = DEPTH/CHUNK; total bytes written = DEPTH exactly.

Reset
REQ-027 rst asserted (any state, incl. mid-transfer): FSM IDLE; busy, done, req_valid, out_valid = 0; req_offset, wr_ptr, rd_ptr, chunk_cnt, rd_data = 0.
REQ-028 Buffer contents SHALL NOT be reset (inferred block RAM).
REQ-029 First start after rst release behaves as REQ-018.

Configuration
REQ-030 Macro FREAD_LOADER_DUMP_EN: defined -> DUMP state and out_* logic present; undefined -> RECV completion goes directly to DONE, out_valid tied 0, out_data tied 0, out_ack ignored.

Structure
REQ-031 Shared package fread_pkg: FSM state encoding, FREAD_LEN_W = 10, default FILE_ID constant.
REQ-032 One sub-module fread_loader_ram (DEPTH x 8, one write port, two registered read ports: rd_addr and rd_ptr).

Verification
REQ-033 DEPTH=64, CHUNK=64, base_offset=0: one request (offset 0, len 63); 64 bytes 0x00..0x3F -> rd_addr 5 gives 0x05, done=1.
REQ-034 DEPTH=256, CHUNK=64, base_offset=0x100: four requests, offsets 0x100/0x140/0x180/0x1C0, each held until req_ready; 256 bytes stored in order.
REQ-035 DUMP_EN, DEPTH=64, out_ack after random 0..30 cycles -> 64 bytes emitted in order, data stable while unacked, done after last ack.
REQ-036 rst pulse after 20 of 64 bytes received -> busy=0, req_valid=0; new start restarts at base_offset with wr_ptr=0.
REQ-037 start while busy and resp_valid while IDLE -> no state change, no buffer write.
REQ-038 base_offset=0xFFFFFFC0, DEPTH=128, CHUNK=64 -> second request offset 0x00000000 (wrap).

Source files
------------

// File: rtl/fread_pkg.sv
// Shared definitions for the fread buffer loader: FSM encoding, request length width and
// the default file ID.
package fread_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRecv,
    StDump,
    StDone
  } fread_state_e;

  localparam int unsigned FREAD_LEN_W = 10;
  localparam logic [31:0] FREAD_FILE_ID = 32'hDABBAD00;

endpackage

// File: rtl/fread_loader_ram.sv
// DEPTH x 8 buffer: one write port and two registered read ports. Storage is not reset so it
// maps onto block RAM; only the read registers clear on reset.
module fread_loader_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_a_q, rdata_b_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking reads give old data on a same-cycle write to the same address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_a_q <= 8'h00;
      rdata_b_q <= 8'h00;
    end else begin
      rdata_a_q <= mem_q[raddr_a_i];
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/fread_loader.sv
// Loads DEPTH bytes of a file into a local buffer through CHUNK-sized fread requests.
// Define FREAD_LOADER_DUMP_EN to stream the buffer out over out_* after each load.
module fread_loader
  import fread_pkg::*;
#(
  parameter logic [31:0] FILE_ID = FREAD_FILE_ID,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned CHUNK   = 64,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            base_offset,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            req_file_id,
  output logic [31:0]            req_offset,
  output logic [FREAD_LEN_W-1:0] req_len,
  output logic                   req_valid,
  input  logic                   req_ready,
  input  logic [7:0]             resp_data,
  input  logic                   resp_valid,
  input  logic [AW-1:0]          rd_addr,
  output logic [7:0]             rd_data,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ack
);

  localparam int unsigned CW = $clog2(CHUNK + 1);

  fread_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [31:0]   req_offset_q, req_offset_d;
  logic          refetch_q, refetch_d;
  logic          mem_we;
  logic [7:0]    dump_data;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    chunk_cnt_d  = chunk_cnt_q;
    req_offset_d = req_offset_q;
    refetch_d    = 1'b0;
    mem_we       = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          chunk_cnt_d  = '0;
          req_offset_d = base_offset;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (req_ready) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (resp_valid) begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          chunk_cnt_d = chunk_cnt_q + 1'b1;
          if (chunk_cnt_q == CW'(CHUNK - 1)) begin
            chunk_cnt_d = '0;
            // CHUNK divides DEPTH, so the buffer can only fill on a chunk boundary.
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
`ifdef FREAD_LOADER_DUMP_EN
              state_d = StDump;
`else
              state_d = StDone;
`endif
            end else begin
              req_offset_d = req_offset_q + 32'(CHUNK);
              state_d      = StReq;
            end
          end
        end
      end
      StDump: begin
`ifdef FREAD_LOADER_DUMP_EN
        if (out_ack && !refetch_q) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          refetch_d = 1'b1;
          if (rd_ptr_q == AW'(DEPTH - 1)) begin
            state_d = StDone;
          end
        end
`else
        state_d = StDone;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      chunk_cnt_q  <= '0;
      req_offset_q <= '0;
      refetch_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      chunk_cnt_q  <= chunk_cnt_d;
      req_offset_q <= req_offset_d;
      refetch_q    <= refetch_d;
    end
  end

  fread_loader_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (mem_we),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (resp_data),
    .raddr_a_i(rd_addr),
    .rdata_a_o(rd_data),
    .raddr_b_i(rd_ptr_q),
    .rdata_b_o(dump_data)
  );

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign req_valid   = (state_q == StReq);
  assign req_file_id = FILE_ID;
  assign req_offset  = req_offset_q;
  assign req_len     = FREAD_LEN_W'(CHUNK - 1);

`ifdef FREAD_LOADER_DUMP_EN
  // The read port lags rd_ptr by a cycle, so valid is withheld for one cycle after each ack.
  assign out_valid = (state_q == StDump) && !refetch_q;
  assign out_data  = dump_data;
`else
  logic unused_dump;
  assign unused_dump = ^{dump_data, out_ack, refetch_q};
  assign out_valid   = 1'b0;
  assign out_data    = 8'h00;
`endif

endmodule

// File: tb/tb_fread_loader.sv
// Directed bench for fread_loader (DEPTH=128, CHUNK=32): multi-chunk loads, offset wrap,
// mid-transfer reset, ignored start/resp_valid and, when FREAD_LOADER_DUMP_EN is set, the dump.
module tb_fread_loader;

  localparam int DEPTH = 128;
  localparam int CHUNK = 32;
  localparam int NREQ  = DEPTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_offset = '0;
  logic        busy, done;
  logic [31:0] req_file_id, req_offset;
  logic [9:0]  req_len;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [7:0]  resp_data = '0;
  logic        resp_valid = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic [7:0]  rd_data, out_data;
  logic        out_valid;
  logic        out_ack = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model [DEPTH];
  logic [31:0] obs_off [NREQ];

  always #5 clk = ~clk;

  fread_loader #(
    .FILE_ID(32'hDABBAD00),
    .DEPTH  (DEPTH),
    .CHUNK  (CHUNK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_offset(base_offset),
    .busy       (busy),
    .done       (done),
    .req_file_id(req_file_id),
    .req_offset (req_offset),
    .req_len    (req_len),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_req_valid();
    int t = 0;
    while (!req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("req_valid_wait", 32'(req_valid), 32'd1);
  endtask

  task automatic read_back(input int a);
    rd_addr = 7'(a);
    @(negedge clk);
    check_eq($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(model[a]));
  endtask

`ifdef FREAD_LOADER_DUMP_EN
  task automatic run_dump();
    for (int k = 0; k < DEPTH; k++) begin
      int t = 0;
      int gap;
      while (!out_valid && t < 10) begin
        @(negedge clk);
        t++;
      end
      check_eq("out_valid_wait", 32'(out_valid), 32'd1);
      gap = int'($urandom_range(0, 30));
      for (int g = 0; g < gap; g++) begin
        check_eq("dump_stable", 32'(out_data), 32'(model[k]));
        @(negedge clk);
        check_eq("dump_valid_held", 32'(out_valid), 32'd1);
      end
      check_eq($sformatf("dump_data[%0d]", k), 32'(out_data), 32'(model[k]));
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      check_eq("dump_refetch_gap", 32'(out_valid), 32'd0);
    end
  endtask
`endif

  // Full load; optionally pulses start mid-RECV, which must be ignored.
  task automatic do_load(input logic [31:0] base, input logic [7:0] seed, input bit inject);
    start       = 1'b1;
    base_offset = base;
    @(negedge clk);
    start       = 1'b0;
    base_offset = 32'h0BAD_0BAD;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    for (int c = 0; c < NREQ; c++) begin
      wait_req_valid();
      obs_off[c] = req_offset;
      check_eq("req_offset", req_offset, base + 32'(c * CHUNK));
      check_eq("req_len", 32'(req_len), 32'd31);
      check_eq("req_file_id", req_file_id, 32'hDABBAD00);
      // resp_valid during REQ must not write the buffer
      resp_valid = 1'b1;
      resp_data  = 8'hEE;
      repeat (2) begin
        @(negedge clk);
        check_eq("req_valid_hold", 32'(req_valid), 32'd1);
        check_eq("req_offset_hold", req_offset, base + 32'(c * CHUNK));
      end
      resp_valid = 1'b0;
      req_ready  = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check_eq("req_valid_drop", 32'(req_valid), 32'd0);
      for (int i = 0; i < CHUNK; i++) begin
        int idx = c * CHUNK + i;
        logic [7:0] d;
        d = 8'(idx) ^ seed;
        if (i % 5 == 2) begin
          resp_valid = 1'b0;
          @(negedge clk);
        end
        if (inject && c == 1 && i == 3) begin
          start       = 1'b1;
          base_offset = 32'h1234_5600;
        end
        resp_valid = 1'b1;
        resp_data  = d;
        model[idx] = d;
        @(negedge clk);
        start = 1'b0;
      end
      resp_valid = 1'b0;
    end
`ifdef FREAD_LOADER_DUMP_EN
    run_dump();
`else
    check_eq("out_valid_tied", 32'(out_valid), 32'd0);
`endif
    check_eq("done_after_load", 32'(done), 32'd1);
    check_eq("busy_after_load", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_req_valid", 32'(req_valid), 32'd0);
    check_eq("rst_req_offset", req_offset, 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes 0x00..0x7F at offsets 0/0x20/0x40/0x60
    do_load(32'h0, 8'h00, 1'b0);
    check_eq("off0_a", obs_off[0], 32'h00);
    check_eq("off1_a", obs_off[1], 32'h20);
    check_eq("off3_a", obs_off[3], 32'h60);
    rd_addr = 7'd5;
    @(negedge clk);
    check_eq("rd_addr5", 32'(rd_data), 32'h05);

    // resp_valid in DONE is ignored
    resp_valid = 1'b1;
    resp_data  = 8'h55;
    repeat (3) @(negedge clk);
    resp_valid = 1'b0;
    check_eq("done_hold", 32'(done), 32'd1);
    for (int a = 0; a < DEPTH; a++) read_back(a);

    // Restart from DONE with a stray start mid-load
    do_load(32'h100, 8'hA5, 1'b1);
    check_eq("off1_b", obs_off[1], 32'h120);
    check_eq("off2_b", obs_off[2], 32'h140);
    check_eq("off3_b", obs_off[3], 32'h160);
    read_back(0);
    read_back(77);

    // Reset after 20 bytes of the first chunk
    start       = 1'b1;
    base_offset = 32'h4000;
    @(negedge clk);
    start = 1'b0;
    wait_req_valid();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      resp_valid = 1'b1;
      resp_data  = 8'hC0 | 8'(i);
      model[i]   = 8'hC0 | 8'(i);
      @(negedge clk);
    end
    resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_req_valid", 32'(req_valid), 32'd0);
    check_eq("mid_rst_req_offset", req_offset, 32'd0);
    check_eq("mid_rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // resp_valid in IDLE is ignored
    resp_valid = 1'b1;
    resp_data  = 8'h77;
    repeat (3) @(negedge clk);
    resp_valid = 1'b0;
    check_eq("idle_busy", 32'(busy), 32'd0);
    for (int a = 0; a < 24; a++) read_back(a);

    do_load(32'h4000, 8'h3C, 1'b0);
    check_eq("restart_off0", obs_off[0], 32'h4000);
    for (int a = 0; a < 40; a++) read_back(a);

    // 32-bit offset wrap
    do_load(32'hFFFF_FFC0, 8'h5A, 1'b0);
    check_eq("wrap_off1", obs_off[1], 32'hFFFF_FFE0);
    check_eq("wrap_off2", obs_off[2], 32'h0000_0000);
    check_eq("wrap_off3", obs_off[3], 32'h0000_0020);
    for (int a = 0; a < DEPTH; a++) read_back(a);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
